// File: rtl/ddr4_app_arbiter_if.sv
// ddr4_app_arbiter_if
// Bundles every non-clock signal between the two clients, the arbiter and the
// DDR4 controller user interface.
//   master modport : the arbiter (drives app_* command/write-data, client ready,
//                    read-return and status)
//   slave modport  : the environment (clients plus the controller) driving
//                    requests, calibration status, app_rdy/app_wdf_rdy and read data
// Signals:
//   init_calib_complete                controller calibrated, grants allowed
//   cN_req_valid/we/addr/wdata/wmask    client request payload (N = 0, 1)
//   cN_req_ready                       one-cycle accept pulse per client
//   cN_rd_valid, rd_data               in-order read return
//   app_addr/cmd/en, app_rdy           controller command handshake
//   app_wdf_data/mask/wren/end, app_wdf_rdy   controller write-data handshake
//   app_rd_data, app_rd_data_valid     controller read return
//   rd_outstanding, tag_underflow      read-tag FIFO status
interface ddr4_app_arbiter_if #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 28,
   parameter int TAG_DEPTH  = 16
);
   localparam int MASK_WIDTH = DATA_WIDTH / 8;
   localparam int CNT_WIDTH  = $clog2(TAG_DEPTH) + 1;

   logic                  init_calib_complete;

   logic                  c0_req_valid;
   logic                  c0_req_we;
   logic [ADDR_WIDTH-1:0] c0_req_addr;
   logic [DATA_WIDTH-1:0] c0_req_wdata;
   logic [MASK_WIDTH-1:0] c0_req_wmask;
   logic                  c0_req_ready;
   logic                  c0_rd_valid;

   logic                  c1_req_valid;
   logic                  c1_req_we;
   logic [ADDR_WIDTH-1:0] c1_req_addr;
   logic [DATA_WIDTH-1:0] c1_req_wdata;
   logic [MASK_WIDTH-1:0] c1_req_wmask;
   logic                  c1_req_ready;
   logic                  c1_rd_valid;

   logic [DATA_WIDTH-1:0] rd_data;

   logic [ADDR_WIDTH-1:0] app_addr;
   logic [2:0]            app_cmd;
   logic                  app_en;
   logic                  app_rdy;
   logic [DATA_WIDTH-1:0] app_wdf_data;
   logic [MASK_WIDTH-1:0] app_wdf_mask;
   logic                  app_wdf_wren;
   logic                  app_wdf_end;
   logic                  app_wdf_rdy;
   logic [DATA_WIDTH-1:0] app_rd_data;
   logic                  app_rd_data_valid;

   logic [CNT_WIDTH-1:0]  rd_outstanding;
   logic                  tag_underflow;

   modport master (
      input  init_calib_complete,
      input  c0_req_valid, c0_req_we, c0_req_addr, c0_req_wdata, c0_req_wmask,
      input  c1_req_valid, c1_req_we, c1_req_addr, c1_req_wdata, c1_req_wmask,
      output c0_req_ready, c0_rd_valid, c1_req_ready, c1_rd_valid, rd_data,
      output app_addr, app_cmd, app_en,
      input  app_rdy,
      output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
      input  app_wdf_rdy,
      input  app_rd_data, app_rd_data_valid,
      output rd_outstanding, tag_underflow
   );

   modport slave (
      output init_calib_complete,
      output c0_req_valid, c0_req_we, c0_req_addr, c0_req_wdata, c0_req_wmask,
      output c1_req_valid, c1_req_we, c1_req_addr, c1_req_wdata, c1_req_wmask,
      input  c0_req_ready, c0_rd_valid, c1_req_ready, c1_rd_valid, rd_data,
      input  app_addr, app_cmd, app_en,
      output app_rdy,
      input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
      output app_wdf_rdy,
      output app_rd_data, app_rd_data_valid,
      input  rd_outstanding, tag_underflow
   );
endinterface

// File: rtl/ddr4_app_arbiter.sv
// ddr4_app_arbiter
// Round-robin arbiter between two single-beat clients (0: KAN weight loader,
// 1: TDA feature buffer) in front of the DDR4 controller app_* interface.
// Issues one request at a time, tags each read with its client ID in a FIFO and
// steers returned read beats back to the issuing client in order.
// Ports:
//   ui_clk    sole clock
//   ui_rst_n  asynchronous active-low reset
//   bus       ddr4_app_arbiter_if.master (client, controller and status signals)
//
// state | meaning
// IDLE  | waiting for an eligible client; latches payload on grant
// ISSUE | app_en and/or app_wdf_wren held until their handshakes complete
// ACK   | cN_req_ready pulsed for the granted client, last_grant updated
module ddr4_app_arbiter #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 28,
   parameter int TAG_DEPTH  = 16      // power of two, >= 2
) (
   input  logic               ui_clk,
   input  logic               ui_rst_n,
   ddr4_app_arbiter_if.master bus
);
   localparam int MASK_WIDTH = DATA_WIDTH / 8;
   localparam int PTR_WIDTH  = $clog2(TAG_DEPTH);
   localparam int CNT_WIDTH  = PTR_WIDTH + 1;
   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

   state_t                state;
   logic                  last_grant;
   logic                  gnt_id;
   logic [ADDR_WIDTH-1:0] app_addr;
   logic [2:0]            app_cmd;
   logic                  app_en;
   logic [DATA_WIDTH-1:0] app_wdf_data;
   logic [MASK_WIDTH-1:0] app_wdf_mask;
   logic                  app_wdf_wren;
   logic                  c0_req_ready;
   logic                  c1_req_ready;

   logic [TAG_DEPTH-1:0]  tag_mem;
   logic [PTR_WIDTH-1:0]  wr_ptr;
   logic [PTR_WIDTH-1:0]  rd_ptr;
   logic [CNT_WIDTH-1:0]  tag_count;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  c0_rd_valid;
   logic                  c1_rd_valid;
   logic                  tag_underflow;

   logic                  tag_full;
   logic                  tag_empty;
   logic                  elig0;
   logic                  elig1;
   logic                  pick;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [MASK_WIDTH-1:0] sel_wmask;
   logic                  cmd_done;
   logic                  wdf_done;
   logic                  tag_push;
   logic                  tag_pop;

   assign tag_full  = (tag_count == CNT_WIDTH'(TAG_DEPTH));
   assign tag_empty = (tag_count == '0);

   // Writes never consume a tag, so only reads are held off by a full FIFO.
   assign elig0 = bus.c0_req_valid && (bus.c0_req_we || !tag_full);
   assign elig1 = bus.c1_req_valid && (bus.c1_req_we || !tag_full);
   assign pick  = (elig0 && elig1) ? ~last_grant : elig1;

   assign sel_we    = pick ? bus.c1_req_we    : bus.c0_req_we;
   assign sel_addr  = pick ? bus.c1_req_addr  : bus.c0_req_addr;
   assign sel_wdata = pick ? bus.c1_req_wdata : bus.c0_req_wdata;
   assign sel_wmask = pick ? bus.c1_req_wmask : bus.c0_req_wmask;

   // A handshake is done if it was never needed, already completed, or completes now.
   assign cmd_done = !app_en || bus.app_rdy;
   assign wdf_done = !app_wdf_wren || bus.app_wdf_rdy;

   assign tag_push = app_en && bus.app_rdy && (app_cmd == CMD_READ);
   assign tag_pop  = bus.app_rd_data_valid && !tag_empty;

   always_ff @(posedge ui_clk or negedge ui_rst_n) begin
      if (!ui_rst_n) begin
         state        <= IDLE;
         last_grant   <= 1'b1;
         gnt_id       <= 1'b0;
         app_addr     <= '0;
         app_cmd      <= CMD_WRITE;
         app_en       <= 1'b0;
         app_wdf_data <= '0;
         app_wdf_mask <= '0;
         app_wdf_wren <= 1'b0;
         c0_req_ready <= 1'b0;
         c1_req_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.init_calib_complete && (elig0 || elig1)) begin
                  gnt_id       <= pick;
                  app_addr     <= sel_addr;
                  app_cmd      <= sel_we ? CMD_WRITE : CMD_READ;
                  app_wdf_data <= sel_wdata;
                  app_wdf_mask <= sel_wmask;
                  app_en       <= 1'b1;
                  app_wdf_wren <= sel_we;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.app_rdy) begin
                  app_en <= 1'b0;
               end
               if (bus.app_wdf_rdy) begin
                  app_wdf_wren <= 1'b0;
               end
               if (cmd_done && wdf_done) begin
                  c0_req_ready <= !gnt_id;
                  c1_req_ready <= gnt_id;
                  state        <= ACK;
               end
            end
            ACK: begin
               c0_req_ready <= 1'b0;
               c1_req_ready <= 1'b0;
               last_grant   <= gnt_id;
               state        <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Tag storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge ui_clk) begin
      if (tag_push) begin
         tag_mem[wr_ptr] <= gnt_id;
      end
   end

   always_ff @(posedge ui_clk or negedge ui_rst_n) begin
      if (!ui_rst_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         tag_count     <= '0;
         rd_data       <= '0;
         c0_rd_valid   <= 1'b0;
         c1_rd_valid   <= 1'b0;
         tag_underflow <= 1'b0;
      end else begin
         if (tag_push) begin
            wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         end
         if (tag_pop) begin
            rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         end
         case ({tag_push, tag_pop})
            2'b10:   tag_count <= tag_count + CNT_WIDTH'(1);
            2'b01:   tag_count <= tag_count - CNT_WIDTH'(1);
            default: tag_count <= tag_count;
         endcase
         if (bus.app_rd_data_valid) begin
            rd_data <= bus.app_rd_data;
         end
         c0_rd_valid <= tag_pop && !tag_mem[rd_ptr];
         c1_rd_valid <= tag_pop && tag_mem[rd_ptr];
         if (bus.app_rd_data_valid && tag_empty) begin
            tag_underflow <= 1'b1;
         end
      end
   end

   assign bus.app_addr       = app_addr;
   assign bus.app_cmd        = app_cmd;
   assign bus.app_en         = app_en;
   assign bus.app_wdf_data   = app_wdf_data;
   assign bus.app_wdf_mask   = app_wdf_mask;
   assign bus.app_wdf_wren   = app_wdf_wren;
   assign bus.app_wdf_end    = app_wdf_wren;   // single-beat writes: end always tracks wren
   assign bus.c0_req_ready   = c0_req_ready;
   assign bus.c1_req_ready   = c1_req_ready;
   assign bus.c0_rd_valid    = c0_rd_valid;
   assign bus.c1_rd_valid    = c1_rd_valid;
   assign bus.rd_data        = rd_data;
   assign bus.rd_outstanding = tag_count;
   assign bus.tag_underflow  = tag_underflow;
endmodule

// File: tb/tb_ddr4_app_arbiter.sv
// tb_ddr4_app_arbiter
// Table-driven bench for ddr4_app_arbiter: each table record presents one or
// both client requests with controller stall counts and the expected winner,
// command, address and accept latency; hand-written sequences cover read
// return order, tag-FIFO full, underflow and reset mid-issue.
module tb_ddr4_app_arbiter;
   localparam int DW = 512;
   localparam int AW = 28;
   localparam int TD = 16;
   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;
   localparam logic [DW-1:0]   C0_WDATA = {64{8'hA5}};
   localparam logic [DW-1:0]   C1_WDATA = {64{8'h3C}};
   localparam logic [DW/8-1:0] C0_WMASK = '0;
   localparam logic [DW/8-1:0] C1_WMASK = 64'hF0F0_0000_0000_FFFF;

   typedef struct {
      logic          c0_v;
      logic          c0_we;
      logic [AW-1:0] c0_addr;
      logic          c1_v;
      logic          c1_we;
      logic [AW-1:0] c1_addr;
      int            cmd_stall;
      int            wdf_stall;
      int            exp_id;
      logic [2:0]    exp_cmd;
      logic [AW-1:0] exp_addr;
      int            exp_edges;   // edges from presenting valid to seeing ready
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   logic ui_clk = 1'b0;
   logic ui_rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   ddr4_app_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_DEPTH(TD)) bus ();

   ddr4_app_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_DEPTH(TD)) dut (
      .ui_clk   (ui_clk),
      .ui_rst_n (ui_rst_n),
      .bus      (bus)
   );

   always #5 ui_clk = ~ui_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic checkb(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic checki(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic checkv(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ui_clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      int  edges;
      int  k;
      bit  granted;
      bit  done;
      bit  is_wr;
      is_wr   = (v.exp_cmd == CMD_WR);
      granted = 0;
      done    = 0;
      edges   = 0;
      k       = 0;
      bus.c0_req_valid = v.c0_v;
      bus.c0_req_we    = v.c0_we;
      bus.c0_req_addr  = v.c0_addr;
      bus.c1_req_valid = v.c1_v;
      bus.c1_req_we    = v.c1_we;
      bus.c1_req_addr  = v.c1_addr;
      bus.app_rdy      = 1'b0;
      bus.app_wdf_rdy  = 1'b0;
      while (!done && edges < 40) begin
         if (granted) begin
            k++;
            bus.app_rdy     = (k > v.cmd_stall);
            bus.app_wdf_rdy = (k > v.wdf_stall);
         end
         tick();
         edges++;
         if (!granted) begin
            if (bus.app_en) begin
               granted = 1;
               checki("grant_cmd", int'(bus.app_cmd), int'(v.exp_cmd));
               checki("grant_addr", int'(bus.app_addr), int'(v.exp_addr));
               checkb("grant_wren", bus.app_wdf_wren, is_wr);
               checkb("grant_wend", bus.app_wdf_end, is_wr);
               if (is_wr) begin
                  checkv("grant_wdata", bus.app_wdf_data, (v.exp_id == 1) ? C1_WDATA : C0_WDATA);
                  checkv("grant_wmask", DW'(bus.app_wdf_mask), DW'((v.exp_id == 1) ? C1_WMASK : C0_WMASK));
               end
            end
         end else begin
            checkb("issue_app_en", bus.app_en, k <= v.cmd_stall);
            checkb("issue_wdf_wren", bus.app_wdf_wren, is_wr && (k <= v.wdf_stall));
         end
         if (bus.c0_req_ready || bus.c1_req_ready) begin
            done = 1;
            checkb("ready_c0", bus.c0_req_ready, v.exp_id == 0);
            checkb("ready_c1", bus.c1_req_ready, v.exp_id == 1);
            checki("ready_latency", edges, v.exp_edges);
         end
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL vec_timeout: no ready after %0d cycles", edges);
      end
      bus.c0_req_valid = 1'b0;
      bus.c1_req_valid = 1'b0;
      tick();
      checkb("ready_pulse_c0", bus.c0_req_ready, 1'b0);
      checkb("ready_pulse_c1", bus.c1_req_ready, 1'b0);
   endtask

   initial begin
      int exp_out;
      int exp_tags[$];
      int n;
      int cyc;
      int c0_cnt;
      int c1_cnt;
      int rd_iss;
      bit got;

      vecs[0]  = '{1'b1, 1'b0, 28'h10,  1'b1, 1'b0, 28'h20,  0, 0, 0, CMD_RD, 28'h10,  2};
      vecs[1]  = '{1'b1, 1'b0, 28'h11,  1'b1, 1'b0, 28'h21,  0, 0, 1, CMD_RD, 28'h21,  2};
      vecs[2]  = '{1'b1, 1'b0, 28'h12,  1'b1, 1'b0, 28'h22,  0, 0, 0, CMD_RD, 28'h12,  2};
      vecs[3]  = '{1'b1, 1'b0, 28'h13,  1'b1, 1'b0, 28'h23,  0, 0, 1, CMD_RD, 28'h23,  2};
      vecs[4]  = '{1'b1, 1'b1, 28'h100, 1'b0, 1'b0, 28'h0,   0, 0, 0, CMD_WR, 28'h100, 2};
      vecs[5]  = '{1'b0, 1'b0, 28'h0,   1'b1, 1'b1, 28'h200, 3, 5, 1, CMD_WR, 28'h200, 7};
      vecs[6]  = '{1'b1, 1'b1, 28'h101, 1'b1, 1'b0, 28'h24,  2, 0, 0, CMD_WR, 28'h101, 4};
      vecs[7]  = '{1'b1, 1'b0, 28'h14,  1'b1, 1'b1, 28'h201, 0, 1, 1, CMD_WR, 28'h201, 3};
      vecs[8]  = '{1'b0, 1'b0, 28'h0,   1'b1, 1'b0, 28'h25,  1, 0, 1, CMD_RD, 28'h25,  3};
      vecs[9]  = '{1'b1, 1'b0, 28'h15,  1'b1, 1'b0, 28'h26,  0, 0, 0, CMD_RD, 28'h15,  2};
      vecs[10] = '{1'b1, 1'b1, 28'h102, 1'b1, 1'b1, 28'h202, 0, 2, 1, CMD_WR, 28'h202, 4};

      ui_rst_n = 1'b0;
      bus.init_calib_complete = 1'b0;
      bus.c0_req_valid = 1'b0;
      bus.c0_req_we    = 1'b0;
      bus.c0_req_addr  = '0;
      bus.c0_req_wdata = C0_WDATA;
      bus.c0_req_wmask = C0_WMASK;
      bus.c1_req_valid = 1'b0;
      bus.c1_req_we    = 1'b0;
      bus.c1_req_addr  = '0;
      bus.c1_req_wdata = C1_WDATA;
      bus.c1_req_wmask = C1_WMASK;
      bus.app_rdy      = 1'b0;
      bus.app_wdf_rdy  = 1'b0;
      bus.app_rd_data  = '0;
      bus.app_rd_data_valid = 1'b0;

      #22;
      checkb("rst_app_en", bus.app_en, 1'b0);
      checkb("rst_wdf_wren", bus.app_wdf_wren, 1'b0);
      checkb("rst_wdf_end", bus.app_wdf_end, 1'b0);
      checki("rst_app_cmd", int'(bus.app_cmd), 0);
      checki("rst_app_addr", int'(bus.app_addr), 0);
      checkv("rst_wdf_data", bus.app_wdf_data, '0);
      checkb("rst_c0_ready", bus.c0_req_ready, 1'b0);
      checkb("rst_c1_ready", bus.c1_req_ready, 1'b0);
      checkb("rst_c0_rd_valid", bus.c0_rd_valid, 1'b0);
      checkb("rst_c1_rd_valid", bus.c1_rd_valid, 1'b0);
      checkv("rst_rd_data", bus.rd_data, '0);
      checki("rst_outstanding", int'(bus.rd_outstanding), 0);
      checkb("rst_underflow", bus.tag_underflow, 1'b0);

      ui_rst_n = 1'b1;
      tick();

      // No grants while calibration is incomplete.
      bus.c0_req_valid = 1'b1;
      bus.c0_req_we    = 1'b1;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.app_en) n++;
      end
      checki("no_grant_uncalibrated", n, 0);
      bus.c0_req_valid = 1'b0;
      tick();
      bus.init_calib_complete = 1'b1;

      exp_out = 0;
      for (int i = 0; i < NV; i++) begin
         run_vec(vecs[i]);
         if (vecs[i].exp_cmd == CMD_RD) begin
            exp_out++;
            exp_tags.push_back(vecs[i].exp_id);
         end
         checki("vec_outstanding", int'(bus.rd_outstanding), exp_out);
      end

      // In-order read return, back-to-back beats, data = beat number.
      n = exp_tags.size();
      for (int i = 0; i < n; i++) begin
         bus.app_rd_data       = DW'(i + 1);
         bus.app_rd_data_valid = 1'b1;
         tick();
         checkb("ret_c0_valid", bus.c0_rd_valid, exp_tags[i] == 0);
         checkb("ret_c1_valid", bus.c1_rd_valid, exp_tags[i] == 1);
         checkv("ret_data", bus.rd_data, DW'(i + 1));
         checki("ret_outstanding", int'(bus.rd_outstanding), n - 1 - i);
      end
      bus.app_rd_data_valid = 1'b0;
      tick();
      checkb("ret_idle_c0", bus.c0_rd_valid, 1'b0);
      checkb("ret_idle_c1", bus.c1_rd_valid, 1'b0);

      // Fill the tag FIFO with continuous client-0 reads.
      bus.app_rdy      = 1'b1;
      bus.app_wdf_rdy  = 1'b1;
      bus.c0_req_valid = 1'b1;
      bus.c0_req_we    = 1'b0;
      bus.c0_req_addr  = 28'h300;
      n = 0;
      cyc = 0;
      while (n < TD && cyc < 200) begin
         tick();
         cyc++;
         if (bus.c0_req_ready) n++;
      end
      checki("fill_grants", n, TD);
      checki("fill_outstanding", int'(bus.rd_outstanding), TD);

      // Full FIFO: c0 read blocked, c1 write still granted.
      bus.c1_req_valid = 1'b1;
      bus.c1_req_we    = 1'b1;
      bus.c1_req_addr  = 28'h400;
      c0_cnt = 0;
      c1_cnt = 0;
      rd_iss = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.app_en && bus.app_cmd == CMD_RD) rd_iss++;
         if (bus.c0_req_ready) c0_cnt++;
         if (bus.c1_req_ready) begin
            c1_cnt++;
            bus.c1_req_valid = 1'b0;
         end
      end
      checki("full_read_issued", rd_iss, 0);
      checki("full_c0_ready", c0_cnt, 0);
      checki("full_c1_write_ready", c1_cnt, 1);
      checki("full_outstanding", int'(bus.rd_outstanding), TD);

      // One returned beat frees a tag and the pending c0 read goes out.
      bus.app_rd_data       = DW'(32'h77);
      bus.app_rd_data_valid = 1'b1;
      tick();
      bus.app_rd_data_valid = 1'b0;
      checkb("free_c0_rd_valid", bus.c0_rd_valid, 1'b1);
      checkv("free_rd_data", bus.rd_data, DW'(32'h77));
      got = 0;
      cyc = 0;
      while (!got && cyc < 10) begin
         tick();
         cyc++;
         if (bus.c0_req_ready) got = 1;
      end
      checkb("free_c0_granted", got, 1'b1);
      bus.c0_req_valid = 1'b0;
      checki("free_outstanding", int'(bus.rd_outstanding), TD);

      // Reset flushes the FIFO.
      ui_rst_n = 1'b0;
      #1;
      checki("flush_outstanding", int'(bus.rd_outstanding), 0);
      tick();
      ui_rst_n = 1'b1;
      tick();

      // Underflow: read beat with nothing outstanding.
      bus.app_rd_data       = DW'(32'h99);
      bus.app_rd_data_valid = 1'b1;
      tick();
      bus.app_rd_data_valid = 1'b0;
      checkb("uf_flag", bus.tag_underflow, 1'b1);
      checkb("uf_no_c0_valid", bus.c0_rd_valid, 1'b0);
      checkb("uf_no_c1_valid", bus.c1_rd_valid, 1'b0);
      checki("uf_outstanding", int'(bus.rd_outstanding), 0);
      tick();
      tick();
      checkb("uf_sticky", bus.tag_underflow, 1'b1);

      // Reset while a write is stalled in ISSUE.
      bus.app_rdy      = 1'b0;
      bus.app_wdf_rdy  = 1'b0;
      bus.c0_req_valid = 1'b1;
      bus.c0_req_we    = 1'b1;
      bus.c0_req_addr  = 28'h500;
      got = 0;
      cyc = 0;
      while (!got && cyc < 10) begin
         tick();
         cyc++;
         if (bus.app_en) got = 1;
      end
      checkb("midrst_granted", got, 1'b1);
      tick();
      ui_rst_n = 1'b0;
      #1;
      checkb("midrst_app_en", bus.app_en, 1'b0);
      checkb("midrst_wdf_wren", bus.app_wdf_wren, 1'b0);
      checkb("midrst_wdf_end", bus.app_wdf_end, 1'b0);
      checki("midrst_app_cmd", int'(bus.app_cmd), 0);
      checki("midrst_app_addr", int'(bus.app_addr), 0);
      checkv("midrst_wdf_data", bus.app_wdf_data, '0);
      checkv("midrst_wdf_mask", DW'(bus.app_wdf_mask), '0);
      checkb("midrst_c0_ready", bus.c0_req_ready, 1'b0);
      checkb("midrst_c1_ready", bus.c1_req_ready, 1'b0);
      checkb("midrst_c0_rd_valid", bus.c0_rd_valid, 1'b0);
      checkb("midrst_c1_rd_valid", bus.c1_rd_valid, 1'b0);
      checkv("midrst_rd_data", bus.rd_data, '0);
      checki("midrst_outstanding", int'(bus.rd_outstanding), 0);
      checkb("midrst_underflow", bus.tag_underflow, 1'b0);
      bus.c0_req_valid = 1'b0;
      tick();
      ui_rst_n = 1'b1;
      tick();
      tick();
      checkb("post_rst_idle", bus.app_en, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
